// File: rtl/oscillator_mixer.sv
// Sweeps all oscillators once per sample tick and sums the active samples into
// one wide word, which is published with a snapshot of the active mask.
module oscillator_mixer #(
    parameter int NUM_OSCILLATORS         = 8,
    parameter int SAMPLE_WIDTH            = 16,
    parameter int PRE_DIVISION_AUDIO_SIZE = 32,
    parameter int IDX_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               sample_tick_in,
    input  logic [NUM_OSCILLATORS-1:0]         osc_active_in,
    output logic [IDX_W-1:0]                   osc_idx_out,
    output logic                               osc_rd_out,
    input  logic [SAMPLE_WIDTH-1:0]            osc_sample_in,
    output logic [PRE_DIVISION_AUDIO_SIZE-1:0] stream_out,
    output logic [NUM_OSCILLATORS-1:0]         is_on_out,
    output logic                               has_updated_out,
    output logic                               busy_out,
    output logic                               overrun_out
);

    if (PRE_DIVISION_AUDIO_SIZE < SAMPLE_WIDTH + $clog2(NUM_OSCILLATORS)) begin : g_width_check
        $error("PRE_DIVISION_AUDIO_SIZE too narrow for NUM_OSCILLATORS samples");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OSCILLATORS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                             state, state_nxt;
    logic [IDX_W-1:0]                   idx, idx_nxt;
    logic [NUM_OSCILLATORS-1:0]         mask;
    logic [PRE_DIVISION_AUDIO_SIZE-1:0] acc;
    logic [PRE_DIVISION_AUDIO_SIZE-1:0] sum_p1;
    logic                               vld_p0;
    logic [IDX_W-1:0]                   idx_p0;
    logic                               start;

    function automatic logic [PRE_DIVISION_AUDIO_SIZE-1:0] masked_sample(
        input logic                    en,
        input logic [SAMPLE_WIDTH-1:0] s
    );
        return en ? PRE_DIVISION_AUDIO_SIZE'(s) : '0;
    endfunction

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        osc_rd_out = 1'b0;
        busy_out   = 1'b0;
        case (state)
            IDLE: begin
                if (sample_tick_in) begin
                    state_nxt = ACCUM;
                    idx_nxt   = '0;
                end
            end
            ACCUM: begin
                osc_rd_out = 1'b1;
                busy_out   = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            DRAIN: begin
                busy_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign osc_idx_out = idx;
    assign start       = (state == IDLE) && sample_tick_in;

    // Stage p1: the sample returned for the read issued last cycle joins the sum
    assign sum_p1 = acc + masked_sample(vld_p0 & mask[idx_p0], osc_sample_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            idx             <= '0;
            mask            <= '0;
            acc             <= '0;
            vld_p0          <= 1'b0;
            idx_p0          <= '0;
            stream_out      <= '0;
            is_on_out       <= '0;
            has_updated_out <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            state           <= state_nxt;
            idx             <= idx_nxt;
            vld_p0          <= osc_rd_out;
            idx_p0          <= idx;
            has_updated_out <= 1'b0;

            if (start) begin
                mask <= osc_active_in;
                acc  <= '0;
            end else if (vld_p0) begin
                acc <= sum_p1;
            end

            // The last sample arrives during DRAIN, so publish its inclusive sum directly
            if (state == DRAIN) begin
                stream_out      <= sum_p1;
                is_on_out       <= mask;
                has_updated_out <= 1'b1;
            end

            if (sample_tick_in && busy_out) begin
                overrun_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oscillator_mixer.sv
// Bench for oscillator_mixer (N=4): table-driven sweeps, scoreboarded publishes,
// plus hand sequences for overrun and reset corner cases.
module tb_oscillator_mixer;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [N-1:0]  active;
    logic [1:0]    osc_idx;
    logic          osc_rd;
    logic [SW-1:0] osc_sample;
    logic [PW-1:0] stream;
    logic [N-1:0]  is_on;
    logic          has_updated;
    logic          busy;
    logic          overrun;

    logic [SW-1:0] samples [N];

    typedef struct packed {
        logic [N-1:0]         mask;
        logic [N-1:0][SW-1:0] s;
        logic [PW-1:0]        sum;
        logic                 midchg;
    } vec_t;

    typedef struct packed {
        logic [PW-1:0] sum;
        logic [N-1:0]  mask;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    vec_t vecs [6];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    oscillator_mixer #(
        .NUM_OSCILLATORS(N),
        .SAMPLE_WIDTH(SW),
        .PRE_DIVISION_AUDIO_SIZE(PW)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .sample_tick_in(tick),
        .osc_active_in(active),
        .osc_idx_out(osc_idx),
        .osc_rd_out(osc_rd),
        .osc_sample_in(osc_sample),
        .stream_out(stream),
        .is_on_out(is_on),
        .has_updated_out(has_updated),
        .busy_out(busy),
        .overrun_out(overrun)
    );

    // Oscillator bank: data for the requested index returns one cycle later
    always @(posedge clk) begin
        if (osc_rd) osc_sample <= samples[osc_idx];
    end

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (has_updated === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_publish: got stream %0h with no pending sweep", stream);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_stream", stream, mon_e.sum);
                chk("sb_is_on", {28'd0, is_on}, {28'd0, mon_e.mask});
            end
        end
    end

    task automatic push_exp(input logic [PW-1:0] sum, input logic [N-1:0] mask);
        exp_t e;
        e.sum  = sum;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic sweep(input vec_t v);
        @(negedge clk);
        for (int i = 0; i < N; i++) samples[i] = v.s[i];
        active = v.mask;
        tick   = 1'b1;
        push_exp(v.sum, v.mask);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) tick = 1'b0;
            if (k == 2 && v.midchg) active = '0;
            chk("rd", {31'd0, osc_rd}, (k <= 4) ? 32'd1 : 32'd0);
            chk("idx", {30'd0, osc_idx}, (k <= 4) ? 32'(k - 1) : 32'd0);
            chk("busy", {31'd0, busy}, (k <= 5) ? 32'd1 : 32'd0);
            chk("upd", {31'd0, has_updated}, (k == 6) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        tick   = 1'b0;
        active = '0;
        for (int i = 0; i < N; i++) samples[i] = '0;

        vecs[0] = '{mask: 4'b1111, s: {16'd400, 16'd300, 16'd200, 16'd100}, sum: 32'd1000, midchg: 1'b0};
        vecs[1] = '{mask: 4'b0101, s: {16'd400, 16'd300, 16'd200, 16'd100}, sum: 32'd400, midchg: 1'b0};
        vecs[2] = '{mask: 4'b1111, s: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, sum: 32'h0003FFFC, midchg: 1'b0};
        vecs[3] = '{mask: 4'b0000, s: {16'd9, 16'd8, 16'd7, 16'd6}, sum: 32'd0, midchg: 1'b0};
        vecs[4] = '{mask: 4'b1111, s: {16'd400, 16'd300, 16'd200, 16'd100}, sum: 32'd1000, midchg: 1'b1};
        vecs[5] = '{mask: 4'b1010, s: {16'd4, 16'd3, 16'd2, 16'd1}, sum: 32'd6, midchg: 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_stream", stream, 32'd0);
        chk("rst_is_on", {28'd0, is_on}, 32'd0);
        chk("rst_upd", {31'd0, has_updated}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", {31'd0, osc_rd}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) sweep(vecs[v]);
        chk("no_overrun_yet", {31'd0, overrun}, 32'd0);

        // Tick while busy is ignored; tick on the publish cycle starts the next sweep
        @(negedge clk);
        for (int i = 0; i < N; i++) samples[i] = vecs[0].s[i];
        active = 4'b1111;
        tick   = 1'b1;
        push_exp(32'd1000, 4'b1111);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            tick = (k == 3 || k == 6);
            if (k == 6) push_exp(32'd1000, 4'b1111);
            if (k == 2) chk("ovr_before", {31'd0, overrun}, 32'd0);
            if (k == 4) chk("ovr_set", {31'd0, overrun}, 32'd1);
            chk("ovr_upd", {31'd0, has_updated}, (k == 6 || k == 12) ? 32'd1 : 32'd0);
        end
        chk("ovr_held", {31'd0, overrun}, 32'd1);
        do_reset();
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
        chk("ovr_rst_stream", stream, 32'd0);

        // Reset in the middle of a sweep aborts without publishing
        sweep(vecs[1]);
        @(negedge clk);
        tick = 1'b1;
        push_exp(32'd1000, 4'b1111);
        active = 4'b1111;
        for (int i = 0; i < N; i++) samples[i] = vecs[0].s[i];
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tick = 1'b0;
        end
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_stream", stream, 32'd0);
        chk("mid_rst_is_on", {28'd0, is_on}, 32'd0);
        chk("mid_rst_rd", {31'd0, osc_rd}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("mid_rst_upd", {31'd0, has_updated}, 32'd0);
            @(negedge clk);
        end

        // Reset wins over a simultaneous tick
        rst  = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b0;
        chk("rst_tick_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst_tick_busy2", {31'd0, busy}, 32'd0);

        sweep(vecs[0]);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
